pipelined_barrel_shifter: RTL and testbench
===========================================

# pipelined_barrel_shifter

Multi-mode, parametrised barrel shifter with one register stage per shift stage and a valid/ready handshake on both sides. It generalises the combinational rotate-left shifter to five shift modes and any power-of-two width. It sits between the operand fetch and result writeback of the datapath, where a single-cycle log-depth mux chain no longer meets timing.

## Interface
Parameters:
- DATA_WIDTH, 8, data width; power of two, ≥ 2
- SHIFT_WIDTH, $clog2(DATA_WIDTH), width of N_SHIFT; also the number of stages and the latency in cycles

Ports:
- CLK  input  1  single clock; all state on rising edge
- RST_N  input  1  asynchronous, active-low reset
- IVALID  input  1  input transaction valid
- IREADY  output  1  shifter accepts input this cycle
- IDATA  input  DATA_WIDTH  operand
- N_SHIFT  input  SHIFT_WIDTH  shift amount, 0..DATA_WIDTH-1
- MODE  input  3  0 ROL, 1 ROR, 2 LSL, 3 LSR, 4 ASR; 5–7 reserved
- OVALID  output  1  result valid
- OREADY  input  1  downstream accepts result
- ODATA  output  DATA_WIDTH  shifted result
- OCARRY  output  1  last bit shifted out; present only with PBS_CARRY_EN

## Operation
- Stage k (k = SHIFT_WIDTH-1 down to 0) shifts by 2**k when its N_SHIFT bit is set, then registers the result. The largest shift comes first.
- Each stage register holds: data, valid, the remaining N_SHIFT bits, MODE and the running carry.
- Global advance: EN = OREADY | ~OVALID. Every stage register loads only when EN is 1.
- IREADY = EN. An input is accepted when IVALID & IREADY.
- Bubbles are not collapsed: the pipeline moves as a rigid shift register.
- Transactions come out in acceptance order. None is dropped or duplicated under any OREADY pattern.
- Shift semantics:
  - ROL/ROR: rotate.
  - LSL/LSR: shift in zeros.
  - ASR: shift in IDATA[DATA_WIDTH-1].
- N_SHIFT = 0 gives ODATA = IDATA in every mode.
- Reserved MODE values behave as ROL.
- Reset (asynchronous, any time, including mid-stream): all valids clear, all data/carry registers clear to 0, OVALID = 0, ODATA = 0, OCARRY = 0.
  - IREADY = 1 during and after reset, because OVALID = 0.
  - In-flight transactions are discarded.

## Timing
- Latency is exactly SHIFT_WIDTH cycles from acceptance to OVALID with OREADY held at 1. For DATA_WIDTH = 8 this is 3 cycles.
- Throughput is one transaction per cycle when OREADY = 1.
- With OREADY = 0 and OVALID = 1, all outputs are held stable until the handshake completes, and IREADY = 0.
- IREADY depends combinationally on OREADY. There is no other combinational in-to-out path.
- A simultaneous input accept and output handshake in the same cycle is legal and is the steady state.

## Configuration
- Macro: PBS_CARRY_EN.
- Defined: the OCARRY port exists, and each stage propagates a carry.
  - LSL: carry = IDATA[DATA_WIDTH-N].
  - LSR/ASR: carry = IDATA[N-1].
  - ROL: carry = ODATA[0].
  - ROR: carry = ODATA[DATA_WIDTH-1].
  - N = 0 in any mode: carry = 0.
- Undefined: no OCARRY port and no carry registers. Data behaviour is identical.

## Structure
- Package pbs_pkg holds:
  - MODE encodings as localparams PBS_ROL..PBS_ASR
  - the 3-bit mode typedef
- Sub-module pbs_stage is instantiated once per stage by a generate loop. Parameters: DATA_WIDTH, SHIFT_WIDTH, N = 2**k. It contains the mode-aware mux, the carry logic and the stage register with the EN enable and asynchronous clear.

## Test plan
All scenarios use DATA_WIDTH = 8, PBS_CARRY_EN defined, and OREADY = 1 unless stated.
- ROL: IDATA = 0x96, N = 3 → ODATA = 0xB4, OCARRY = 0, OVALID exactly 3 cycles after acceptance. ROR with the same IDATA and N → ODATA = 0xD2, OCARRY = 1.
- ASR: IDATA = 0x96, N = 2 → ODATA = 0xE5, OCARRY = 1. LSR with the same inputs → ODATA = 0x25, OCARRY = 1.
- LSL: IDATA = 0x96, N = 5 → ODATA = 0xC0, OCARRY = 0. Any mode with N = 0 → ODATA = 0x96, OCARRY = 0.
- Back-to-back: 8 transactions in consecutive cycles → 8 results in consecutive cycles, in order, each matching the reference model.
- Backpressure: stream 6 transactions and hold OREADY = 0 for 5 cycles.
  - IREADY drops in the same cycle OVALID rises.
  - ODATA is held stable while stalled.
  - All 6 results arrive in order after OREADY = 1.
- Reset: assert RST_N = 0 mid-stream with 3 transactions in flight.
  - OVALID, ODATA and OCARRY go to 0 immediately (asynchronous).
  - No stale result appears after release.
  - The first new input has a latency of 3.

Source files
------------

// File: rtl/pbs_pkg.sv
// Shared mode encodings and types for the pipelined barrel shifter.
// No logic, no latency.
// No flow control; types only.
package pbs_pkg;

  typedef logic [2:0] pbs_mode_t;

  localparam pbs_mode_t PBS_ROL = 3'd0;
  localparam pbs_mode_t PBS_ROR = 3'd1;
  localparam pbs_mode_t PBS_LSL = 3'd2;
  localparam pbs_mode_t PBS_LSR = 3'd3;
  localparam pbs_mode_t PBS_ASR = 3'd4;

endpackage

// File: rtl/pbs_stage.sv
// One shifter stage: conditional mode-aware shift by N, then register (carry with PBS_CARRY_EN).
// Latency: 1 cycle.
// Backpressure: register loads only when en is high, otherwise holds.
module pbs_stage
  import pbs_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 3,
  parameter int N           = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
`ifdef PBS_CARRY_EN
  input  logic                   d_carry,
  output logic                   q_carry,
`endif
  input  logic                   d_vld,
  input  logic [DATA_WIDTH-1:0]  d_dat,
  input  logic [SHIFT_WIDTH-1:0] d_shift,
  input  logic [2:0]             d_mode,
  output logic                   q_vld,
  output logic [DATA_WIDTH-1:0]  q_dat,
  output logic [SHIFT_WIDTH-1:0] q_shift,
  output logic [2:0]             q_mode
);

  localparam int K = $clog2(N);

  logic [DATA_WIDTH-1:0] rol_dat, ror_dat, lsl_dat, lsr_dat, asr_dat;
  logic [DATA_WIDTH-1:0] sh_dat;

  assign rol_dat = {d_dat[DATA_WIDTH-N-1:0], d_dat[DATA_WIDTH-1:DATA_WIDTH-N]};
  assign ror_dat = {d_dat[N-1:0], d_dat[DATA_WIDTH-1:N]};
  assign lsl_dat = {d_dat[DATA_WIDTH-N-1:0], {N{1'b0}}};
  assign lsr_dat = {{N{1'b0}}, d_dat[DATA_WIDTH-1:N]};
  // Earlier ASR stages preserve the MSB, so it still carries the operand sign.
  assign asr_dat = {{N{d_dat[DATA_WIDTH-1]}}, d_dat[DATA_WIDTH-1:N]};

  always_comb begin
    sh_dat = d_dat;
    if (d_shift[K]) begin
      case (d_mode)
        PBS_ROR: sh_dat = ror_dat;
        PBS_LSL: sh_dat = lsl_dat;
        PBS_LSR: sh_dat = lsr_dat;
        PBS_ASR: sh_dat = asr_dat;
        default: sh_dat = rol_dat;
      endcase
    end
  end

`ifdef PBS_CARRY_EN
  logic sh_carry;

  // A stage that does not shift passes the carry of the stage above unchanged.
  always_comb begin
    sh_carry = d_carry;
    if (d_shift[K]) begin
      case (d_mode)
        PBS_ROR:          sh_carry = ror_dat[DATA_WIDTH-1];
        PBS_LSL:          sh_carry = d_dat[DATA_WIDTH-N];
        PBS_LSR, PBS_ASR: sh_carry = d_dat[N-1];
        default:          sh_carry = rol_dat[0];
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_vld   <= 1'b0;
      q_dat   <= '0;
      q_shift <= '0;
      q_mode  <= '0;
`ifdef PBS_CARRY_EN
      q_carry <= 1'b0;
`endif
    end else if (en) begin
      q_vld   <= d_vld;
      q_dat   <= sh_dat;
      q_shift <= d_shift;
      q_mode  <= d_mode;
`ifdef PBS_CARRY_EN
      q_carry <= sh_carry;
`endif
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Multi-mode barrel shifter, one register per log2 stage; OCARRY exists with PBS_CARRY_EN.
// Latency: SHIFT_WIDTH cycles, one result per cycle.
// Backpressure: whole pipe stalls rigidly when OVALID & ~OREADY; IREADY follows.
module pipelined_barrel_shifter
  import pbs_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IVALID,
  output logic                   IREADY,
  input  logic [DATA_WIDTH-1:0]  IDATA,
  input  logic [SHIFT_WIDTH-1:0] N_SHIFT,
  input  logic [2:0]             MODE,
  output logic                   OVALID,
  input  logic                   OREADY,
  output logic [DATA_WIDTH-1:0]  ODATA
`ifdef PBS_CARRY_EN
  ,
  output logic                   OCARRY
`endif
);

  // Level SHIFT_WIDTH is the input side; level 0 is the output register.
  logic                   vld [0:SHIFT_WIDTH];
  logic [DATA_WIDTH-1:0]  dat [0:SHIFT_WIDTH];
  logic [SHIFT_WIDTH-1:0] shf [0:SHIFT_WIDTH];
  pbs_mode_t              mde [0:SHIFT_WIDTH];
  logic                   en;

  assign en     = OREADY | ~OVALID;
  assign IREADY = en;

  assign vld[SHIFT_WIDTH] = IVALID;
  assign dat[SHIFT_WIDTH] = IDATA;
  assign shf[SHIFT_WIDTH] = N_SHIFT;
  assign mde[SHIFT_WIDTH] = MODE;

  assign OVALID = vld[0];
  assign ODATA  = dat[0];

`ifdef PBS_CARRY_EN
  logic carry [0:SHIFT_WIDTH];
  assign carry[SHIFT_WIDTH] = 1'b0;
  assign OCARRY             = carry[0];
`endif

  for (genvar k = 0; k < SHIFT_WIDTH; k++) begin : g_stage
    pbs_stage #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .N           (1 << k)
    ) u_stage (
      .clk     (CLK),
      .rst_n   (RST_N),
      .en      (en),
`ifdef PBS_CARRY_EN
      .d_carry (carry[k+1]),
      .q_carry (carry[k]),
`endif
      .d_vld   (vld[k+1]),
      .d_dat   (dat[k+1]),
      .d_shift (shf[k+1]),
      .d_mode  (mde[k+1]),
      .q_vld   (vld[k]),
      .q_dat   (dat[k]),
      .q_shift (shf[k]),
      .q_mode  (mde[k])
    );
  end

  // Shift amount and mode are spent once the last stage has used them.
  logic unused_tail;
  assign unused_tail = ^{shf[0], mde[0]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter, DATA_WIDTH = 8.
// Carry is checked when PBS_CARRY_EN is defined; otherwise only data.
module tb_pipelined_barrel_shifter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IVALID;
  logic       IREADY;
  logic [7:0] IDATA;
  logic [2:0] N_SHIFT;
  logic [2:0] MODE;
  logic       OVALID;
  logic       OREADY;
  logic [7:0] ODATA;
  logic [8:0] obs;

  int errors = 0;
  int checks = 0;

`ifdef PBS_CARRY_EN
  logic OCARRY;
  localparam logic [8:0] CMASK = 9'h1FF;
  assign obs = {OCARRY, ODATA};
`else
  localparam logic [8:0] CMASK = 9'h0FF;
  assign obs = {1'b0, ODATA};
`endif

  pipelined_barrel_shifter #(.DATA_WIDTH(8)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .IVALID  (IVALID),
    .IREADY  (IREADY),
    .IDATA   (IDATA),
    .N_SHIFT (N_SHIFT),
    .MODE    (MODE),
    .OVALID  (OVALID),
    .OREADY  (OREADY),
`ifdef PBS_CARRY_EN
    .OCARRY  (OCARRY),
`endif
    .ODATA   (ODATA)
  );

  always #5 CLK = ~CLK;

  // Single-bit-at-a-time reference: {carry, data}.
  function automatic logic [8:0] ref_shift(input logic [7:0] d, input logic [2:0] n,
                                           input logic [2:0] m);
    logic [7:0] v;
    logic       c;
    v = d;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (m)
        3'd1:    begin v = {v[0], v[7:1]}; c = v[7]; end
        3'd2:    begin c = v[7]; v = {v[6:0], 1'b0}; end
        3'd3:    begin c = v[0]; v = {1'b0, v[7:1]}; end
        3'd4:    begin c = v[0]; v = {v[7], v[7:1]}; end
        default: begin v = {v[6:0], v[7]}; c = v[0]; end
      endcase
    end
    return {c, v} & CMASK;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [2:0] m, input logic [7:0] d, input logic [2:0] n);
    IVALID  = 1'b1;
    MODE    = m;
    IDATA   = d;
    N_SHIFT = n;
    tick();
    IVALID  = 1'b0;
  endtask

  task automatic test_reset;
    RST_N = 1'b0; IVALID = 1'b0; OREADY = 1'b1;
    IDATA = '0; N_SHIFT = '0; MODE = '0;
    #2;
    checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b want 0", OVALID); end
    checks++; if (obs !== 9'h000) begin errors++; $display("FAIL reset_out: got %h want 000", obs); end
    checks++; if (IREADY !== 1'b1) begin errors++; $display("FAIL reset_iready: got %b want 1", IREADY); end
    tick(); tick();
    RST_N = 1'b1;
    tick();
  endtask

  // Hand-computed vectors: mode, data, shift, {carry, result}.
  logic [2:0] dir_m [10];
  logic [7:0] dir_d [10];
  logic [2:0] dir_n [10];
  logic [8:0] dir_e [10];

  task automatic test_directed;
    dir_m = '{3'd0, 3'd1, 3'd4, 3'd3, 3'd2, 3'd5, 3'd4, 3'd2, 3'd3, 3'd1};
    dir_d = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96, 8'h81, 8'h80, 8'h01};
    dir_n = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd5, 3'd3, 3'd7, 3'd1, 3'd7, 3'd1};
    dir_e = '{9'h0B4, 9'h1D2, 9'h1E5, 9'h125, 9'h0C0, 9'h0B4, 9'h0FF, 9'h102, 9'h001, 9'h180};
    for (int i = 0; i < 10; i++) begin
      send(dir_m[i], dir_d[i], dir_n[i]);
      checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL directed[%0d] lat1: ovalid %b want 0", i, OVALID); end
      tick();
      checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL directed[%0d] lat2: ovalid %b want 0", i, OVALID); end
      tick();
      checks++; if (OVALID !== 1'b1) begin errors++; $display("FAIL directed[%0d] lat3: ovalid %b want 1", i, OVALID); end
      checks++; if (obs !== (dir_e[i] & CMASK)) begin
        errors++; $display("FAIL directed[%0d] result: got %h want %h", i, obs, dir_e[i] & CMASK);
      end
      tick();
    end
  endtask

  task automatic test_zero_shift;
    for (int m = 0; m < 8; m++) begin
      send(3'(m), 8'h96, 3'd0);
      tick(); tick();
      checks++; if (OVALID !== 1'b1 || obs !== 9'h096) begin
        errors++; $display("FAIL zero_shift[mode %0d]: vld %b got %h want 096", m, OVALID, obs);
      end
      tick();
    end
  endtask

  logic [7:0] bb_d [8];
  logic [2:0] bb_n [8];
  logic [2:0] bb_m [8];

  task automatic test_back_to_back;
    bb_d = '{8'h96, 8'h3C, 8'hA5, 8'hF0, 8'h0F, 8'h81, 8'h7E, 8'h55};
    bb_n = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    bb_m = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd7};
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        IVALID = 1'b1; IDATA = bb_d[c]; N_SHIFT = bb_n[c]; MODE = bb_m[c];
      end else begin
        IVALID = 1'b0;
      end
      if (c >= 3 && c < 11) begin
        checks++; if (OVALID !== 1'b1 || obs !== ref_shift(bb_d[c-3], bb_n[c-3], bb_m[c-3])) begin
          errors++; $display("FAIL b2b[%0d]: vld %b got %h want %h", c - 3, OVALID, obs,
                             ref_shift(bb_d[c-3], bb_n[c-3], bb_m[c-3]));
        end
      end else begin
        checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL b2b_idle[c%0d]: ovalid %b want 0", c, OVALID); end
      end
      tick();
    end
  endtask

  logic [7:0] bp_d [6];
  logic [2:0] bp_n [6];
  logic [2:0] bp_m [6];

  task automatic test_backpressure;
    logic [8:0] q[$];
    logic [8:0] want;
    logic [7:0] held;
    int sent;
    int got;
    bp_d = '{8'h96, 8'hC3, 8'h5A, 8'h01, 8'h80, 8'hE7};
    bp_n = '{3'd3, 3'd1, 3'd4, 3'd7, 3'd2, 3'd5};
    bp_m = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2};
    sent = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      OREADY = (cyc >= 8);
      if (sent < 6) begin
        IVALID = 1'b1; IDATA = bp_d[sent]; N_SHIFT = bp_n[sent]; MODE = bp_m[sent];
      end else begin
        IVALID = 1'b0;
      end
      #1;
      if (cyc == 2) begin
        checks++; if (OVALID !== 1'b0 || IREADY !== 1'b1) begin
          errors++; $display("FAIL bp_pre_stall: ovalid %b iready %b want 0 1", OVALID, IREADY);
        end
      end
      if (cyc == 3) begin
        checks++; if (OVALID !== 1'b1 || IREADY !== 1'b0) begin
          errors++; $display("FAIL bp_stall_edge: ovalid %b iready %b want 1 0", OVALID, IREADY);
        end
        held = ODATA;
      end
      if (cyc > 3 && cyc < 8) begin
        checks++; if (OVALID !== 1'b1 || IREADY !== 1'b0 || ODATA !== held) begin
          errors++; $display("FAIL bp_hold[c%0d]: ovalid %b iready %b odata %h want 1 0 %h",
                             cyc, OVALID, IREADY, ODATA, held);
        end
      end
      if (OVALID && OREADY) begin
        want = (q.size() > 0) ? q.pop_front() : 9'h1xx;
        checks++; if (obs !== want) begin
          errors++; $display("FAIL bp_result[%0d]: got %h want %h", got, obs, want);
        end
        got++;
      end
      if (IVALID && IREADY) begin
        q.push_back(ref_shift(bp_d[sent], bp_n[sent], bp_m[sent]));
        sent++;
      end
      tick();
    end
    IVALID = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", got); end
  endtask

  task automatic test_mid_reset;
    OREADY = 1'b1;
    send(3'd0, 8'h96, 3'd3);
    send(3'd1, 8'hA5, 3'd1);
    send(3'd2, 8'hFF, 3'd1);
    checks++; if (OVALID !== 1'b1 || obs === 9'h000) begin
      errors++; $display("FAIL rst_inflight: ovalid %b out %h want 1 nonzero", OVALID, obs);
    end
    #2;
    RST_N = 1'b0;
    #1;
    checks++; if (OVALID !== 1'b0 || obs !== 9'h000 || IREADY !== 1'b1) begin
      errors++; $display("FAIL rst_async: ovalid %b out %h iready %b want 0 000 1", OVALID, obs, IREADY);
    end
    tick(); tick();
    RST_N = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL rst_stale[c%0d]: ovalid %b want 0", c, OVALID); end
    end
    send(3'd4, 8'h96, 3'd2);
    checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL rst_lat1: ovalid %b want 0", OVALID); end
    tick();
    checks++; if (OVALID !== 1'b0) begin errors++; $display("FAIL rst_lat2: ovalid %b want 0", OVALID); end
    tick();
    checks++; if (OVALID !== 1'b1 || obs !== (9'h1E5 & CMASK)) begin
      errors++; $display("FAIL rst_first: vld %b got %h want %h", OVALID, obs, 9'h1E5 & CMASK);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_shift();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
